// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder
//   Builds RV32I instruction words from a symbolic request (class, registers,
//   funct3, funct7[5], immediate) and writes them to consecutive words of the
//   instruction memory. It serves as the program loader and self-test
//   generator for the single-cycle core.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; in_ready=1
//   ENC   | request fields held; legality checked, word/address registered
//   WRITE | mem_we=1 for this cycle; the pointer advances at its end
//   FULL  | DEPTH words written; left only by clear or reset
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   clear                 synchronous return to IDLE with pointer/count at 0
//   in_valid / in_ready   request handshake
//   in_class              0 lw, 1 sw, 2 R, 3 beq, 4 I-ALU, 5 jal, 6 jalr, 7 illegal
//   in_funct3, in_f7b5    funct3 and instr[30] for R / I-ALU
//   in_rd/rs1/rs2, in_imm register fields and signed immediate
//   mem_we/addr/wdata     imem write port (byte address = 4*pointer)
//   full, err, word_count status
module riscv_instr_encoder #(
    parameter int DEPTH = 64,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_class,
    input  logic [2:0]    in_funct3,
    input  logic          in_f7b5,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          full,
    output logic          err,
    output logic [AW-1:0] word_count
);

    localparam int PW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [AW-1:0]   word_count_q;
    logic            we_q;
    logic            err_q;
    logic            full_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic [2:0]      cls_q;
    logic [2:0]      f3_q;
    logic            f7b5_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [31:0]     imm_q;

    logic [31:0]     word_d;
    logic            legal_d;
    logic signed [31:0] simm;
    logic            shift_op;

    assign simm     = $signed(imm_q);
    assign shift_op = (f3_q == 3'b001) || (f3_q == 3'b101);

    // Encoding and legality of the held request, consumed in ENC.
    always_comb begin
        word_d  = 32'h0;
        legal_d = 1'b0;
        case (cls_q)
            3'd0: begin
                word_d  = {imm_q[11:0], rs1_q, 3'b010, rd_q, OP_LOAD};
                legal_d = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            3'd1: begin
                word_d  = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], OP_STORE};
                legal_d = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            3'd2: begin
                word_d  = {1'b0, f7b5_q, 5'b0, rs2_q, rs1_q, f3_q, rd_q, OP_REG};
                legal_d = 1'b1;
            end
            3'd3: begin
                word_d  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                           imm_q[4:1], imm_q[11], OP_BRANCH};
                legal_d = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm_q[0];
            end
            3'd4: begin
                if (shift_op) begin
                    // slli/srli/srai: shamt in [24:20], only srai sets bit 30
                    word_d  = {1'b0, f7b5_q & f3_q[2], 5'b0, imm_q[4:0], rs1_q,
                               f3_q, rd_q, OP_IMM};
                    legal_d = (simm >= 32'sd0) && (simm <= 32'sd31);
                end else begin
                    word_d  = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_IMM};
                    legal_d = (simm >= -32'sd2048) && (simm <= 32'sd2047);
                end
            end
            3'd5: begin
                word_d  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OP_JAL};
                legal_d = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm_q[0];
            end
            3'd6: begin
                word_d  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OP_JALR};
                legal_d = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            default: begin
                word_d  = 32'h0;
                legal_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            word_count_q <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            full_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            cls_q        <= 3'd0;
            f3_q         <= 3'd0;
            f7b5_q       <= 1'b0;
            rd_q         <= 5'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            imm_q        <= 32'h0;
        end else if (clear) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            word_count_q <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            we_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cls_q   <= in_class;
                        f3_q    <= in_funct3;
                        f7b5_q  <= in_f7b5;
                        rd_q    <= in_rd;
                        rs1_q   <= in_rs1;
                        rs2_q   <= in_rs2;
                        imm_q   <= in_imm;
                        state_q <= S_ENC;
                    end
                end
                S_ENC: begin
                    if (legal_d) begin
                        wdata_q <= word_d;
                        addr_q  <= AW'({ptr_q, 2'b00});
                        we_q    <= 1'b1;
                        state_q <= S_WRITE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    ptr_q        <= ptr_q + PW'(1);
                    word_count_q <= word_count_q + AW'(1);
                    if (ptr_q == PW'(DEPTH - 1)) begin
                        full_q  <= 1'b1;
                        state_q <= S_FULL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FULL: begin
                    state_q <= S_FULL;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    // A clear arriving in the WRITE cycle cancels the strobe itself.
    assign mem_we     = we_q & ~clear;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign full       = full_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Scoreboard bench for riscv_instr_encoder: the driver queues each expected
// write (address, word) or error pulse; the monitor pops and compares them
// whenever the DUT raises mem_we or err.
module tb_riscv_instr_encoder;

    localparam int DEPTH = 64;
    localparam int AW    = 8;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_class;
    logic [2:0]    in_funct3;
    logic          in_f7b5;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          full;
    logic          err;
    logic [AW-1:0] word_count;

    riscv_instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_funct3  (in_funct3),
        .in_f7b5    (in_f7b5),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .full       (full),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   exp_ptr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset && (mem_we || err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, err, mem_we}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    chk("err_pulse", {31'd0, err}, 32'd1);
                    chk("err_no_we", {31'd0, mem_we}, 32'd0);
                end else begin
                    chk("we_no_err", {31'd0, err}, 32'd0);
                    chk("mem_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                    chk("mem_wdata", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
        in_class  = c;
        in_funct3 = f3;
        in_f7b5   = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] data);
        exp_t e;
        e.is_err = 1'b0;
        e.addr   = 8'(exp_ptr * 4);
        e.data   = data;
        exp_q.push_back(e);
        exp_ptr++;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.addr   = 8'd0;
        e.data   = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_class = 3'd0; in_funct3 = 3'd0; in_f7b5 = 1'b0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wcount", {24'd0, word_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // lw x5,8(x2) with latency check: strobe in the second cycle after accept
        send(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8);
        push_wr(32'h00812283);
        @(negedge clk);
        chk("lat_cycle1_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2_we", {31'd0, mem_we}, 32'd1);

        send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);          // add x3,x1,x2
        push_wr(32'h002081B3);
        send(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);          // sub x3,x1,x2
        push_wr(32'h402081B3);
        drain();
        chk("wcount_3", {24'd0, word_count}, 32'd3);

        send(3'd3, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 32'hFFFF_FFFC);  // beq x1,x2,-4
        push_wr(32'hFE208EE3);
        send(3'd5, 3'd0, 1'b0, 5'd1, 5'd7, 5'd7, 32'd8);          // jal x1,8
        push_wr(32'h008000EF);
        send(3'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd3, 32'd0);          // jalr x0,0(x1)
        push_wr(32'h00008067);
        send(3'd1, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);  // sw x5,-4(x2)
        push_wr(32'hFE512E23);
        send(3'd4, 3'd5, 1'b1, 5'd4, 5'd6, 5'd0, 32'd3);          // srai x4,x6,3
        push_wr(32'h40335213);
        drain();
        chk("wcount_8", {24'd0, word_count}, 32'd8);

        send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);          // odd branch offset
        push_err();
        send(3'd4, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048);       // addi out of range
        push_err();
        send(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);          // reserved class
        push_err();
        drain();
        chk("wcount_after_err", {24'd0, word_count}, 32'd8);
        // Next legal write must land right after the last good one
        send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);          // addi x1,x0,1
        push_wr(32'h00100093);
        drain();

        // clear coinciding with the write strobe suppresses the write
        send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(posedge clk);
        #1 clear = 1'b1;
        #1 chk("clear_kills_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        chk("clear_wcount", {24'd0, word_count}, 32'd0);
        exp_ptr = 0;

        // Fill all DEPTH words with addi x(i%32),x0,i
        for (int i = 0; i < DEPTH; i++) begin
            send(3'd4, 3'd0, 1'b0, 5'(i % 32), 5'd0, 5'd0, i);
            push_wr({12'(i), 5'd0, 3'b000, 5'(i % 32), 7'b0010011});
        end
        drain();
        chk("full_set", {31'd0, full}, 32'd1);
        chk("full_not_ready", {31'd0, in_ready}, 32'd0);
        chk("full_wcount", {24'd0, word_count}, 32'd64);
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        chk("full_wcount_hold", {24'd0, word_count}, 32'd64);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_full", {31'd0, full}, 32'd0);
        chk("clear_ready", {31'd0, in_ready}, 32'd1);
        chk("clear_wcount0", {24'd0, word_count}, 32'd0);
        exp_ptr = 0;

        send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);          // addi x1,x0,1
        push_wr(32'h00100093);
        drain();

        // Reset asserted during WRITE
        send(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rstw_we", {31'd0, mem_we}, 32'd0);
        chk("rstw_addr", {24'd0, mem_addr}, 32'd0);
        chk("rstw_wdata", mem_wdata, 32'd0);
        chk("rstw_wcount", {24'd0, word_count}, 32'd0);
        chk("rstw_full", {31'd0, full}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ptr = 0;
        send(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8);
        push_wr(32'h00812283);
        drain();
        chk("final_wcount", {24'd0, word_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
